// File: rtl/move_executor.sv
// Move executor: checks a move on the 10x10 bordered board RAM,
// flips bracketed discs along all 8 rays, then places the disc.
module move_executor #(
  parameter int ADDR_W     = 7,
  parameter int ROW_STRIDE = 10,
  parameter int CELLS      = 100
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              board_ready,
  input  logic              start,
  input  logic [ADDR_W-1:0] pos,
  input  logic [1:0]        player,
  output logic              busy,
  output logic              done,
  output logic              legal,
  output logic [4:0]        flip_count,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [1:0]        ram_wdata,
  output logic              ram_wren,
  input  logic [1:0]        ram_rdata
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_DIR,
    S_SCAN,
    S_FLIP,
    S_NEXT,
    S_PLACE,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic              ph_q, ph_d;
  logic [ADDR_W-1:0] pos_q, pos_d;
  logic [1:0]        player_q, player_d;
  logic [2:0]        dir_q, dir_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [2:0]        run_q, run_d;
  logic [2:0]        k_q, k_d;
  logic [4:0]        flip_q, flip_d;
  logic              legal_q, legal_d;

  logic              bad_req;
  logic [1:0]        opp;
  logic [ADDR_W-1:0] step;

  function automatic logic [ADDR_W-1:0] off(
    input logic [2:0] d
  );
    logic [ADDR_W-1:0] r;
    unique case (d)
      3'd0: r = ADDR_W'(-(ROW_STRIDE + 1));
      3'd1: r = ADDR_W'(-ROW_STRIDE);
      3'd2: r = ADDR_W'(-(ROW_STRIDE - 1));
      3'd3: r = ADDR_W'(-1);
      3'd4: r = ADDR_W'(1);
      3'd5: r = ADDR_W'(ROW_STRIDE - 1);
      3'd6: r = ADDR_W'(ROW_STRIDE);
      3'd7: r = ADDR_W'(ROW_STRIDE + 1);
      default: r = '0;
    endcase
    return r;
  endfunction

  assign bad_req = (pos_q >= ADDR_W'(CELLS))
                || (player_q == 2'b00)
                || (player_q == 2'b11);
  assign opp  = ~player_q;
  assign step = off(dir_q);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      ph_q     <= 1'b0;
      pos_q    <= '0;
      player_q <= '0;
      dir_q    <= '0;
      ptr_q    <= '0;
      run_q    <= '0;
      k_q      <= '0;
      flip_q   <= '0;
      legal_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      ph_q     <= ph_d;
      pos_q    <= pos_d;
      player_q <= player_d;
      dir_q    <= dir_d;
      ptr_q    <= ptr_d;
      run_q    <= run_d;
      k_q      <= k_d;
      flip_q   <= flip_d;
      legal_q  <= legal_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ph_d     = ph_q;
    pos_d    = pos_q;
    player_d = player_q;
    dir_d    = dir_q;
    ptr_d    = ptr_q;
    run_d    = run_q;
    k_d      = k_q;
    flip_d   = flip_q;
    legal_d  = legal_q;
    unique case (state_q)
      S_IDLE: begin
        if (start && board_ready) begin
          pos_d    = pos;
          player_d = player;
          flip_d   = '0;
          legal_d  = 1'b0;
          ph_d     = 1'b0;
          state_d  = S_CHECK;
        end
      end
      S_CHECK: begin
        if (!ph_q) begin
          if (bad_req) state_d = S_DONE;
          else         ph_d    = 1'b1;
        end else begin
          ph_d = 1'b0;
          if (ram_rdata != 2'b00) begin
            state_d = S_DONE;
          end else begin
            dir_d   = '0;
            state_d = S_DIR;
          end
        end
      end
      S_DIR: begin
        ptr_d   = pos_q + step;
        run_d   = '0;
        ph_d    = 1'b0;
        state_d = S_SCAN;
      end
      S_SCAN: begin
        if (!ph_q) begin
          ph_d = 1'b1;
        end else begin
          ph_d = 1'b0;
          if (ram_rdata == opp && run_q != 3'd7) begin
            run_d = run_q + 3'd1;
            ptr_d = ptr_q + step;
          end else if (ram_rdata == player_q
                       && run_q != 3'd0) begin
            ptr_d   = pos_q + step;
            k_d     = 3'd1;
            state_d = S_FLIP;
          end else begin
            state_d = S_NEXT;
          end
        end
      end
      S_FLIP: begin
        ptr_d = ptr_q + step;
        k_d   = k_q + 3'd1;
        if (k_q == run_q) begin
          flip_d  = flip_q + {2'b00, run_q};
          state_d = S_NEXT;
        end
      end
      S_NEXT: begin
        if (dir_q == 3'd7) begin
          state_d = (flip_q != '0) ? S_PLACE : S_DONE;
        end else begin
          dir_d   = dir_q + 3'd1;
          state_d = S_DIR;
        end
      end
      S_PLACE: begin
        legal_d = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy       = (state_q != S_IDLE)
              && (state_q != S_DONE);
    done       = (state_q == S_DONE);
    legal      = legal_q;
    flip_count = flip_q;
    ram_wren   = 1'b0;
    ram_wdata  = '0;
    ram_addr   = '0;
    unique case (state_q)
      S_CHECK: begin
        if (!bad_req) ram_addr = pos_q;
      end
      S_SCAN: begin
        ram_addr = ptr_q;
      end
      S_FLIP: begin
        ram_addr  = ptr_q;
        ram_wren  = 1'b1;
        ram_wdata = player_q;
      end
      S_PLACE: begin
        ram_addr  = pos_q;
        ram_wren  = 1'b1;
        ram_wdata = player_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_move_executor.sv
// Directed bench for move_executor with a board RAM model
// and a scoreboard of expected results and RAM writes.
module tb_move_executor;

  logic       clock;
  logic       reset;
  logic       board_ready;
  logic       start;
  logic [6:0] pos;
  logic [1:0] player;
  logic       busy;
  logic       done;
  logic       legal;
  logic [4:0] flip_count;
  logic [6:0] ram_addr;
  logic [1:0] ram_wdata;
  logic       ram_wren;
  logic [1:0] ram_rdata;

  move_executor dut (
    .clock       (clock),
    .reset       (reset),
    .board_ready (board_ready),
    .start       (start),
    .pos         (pos),
    .player      (player),
    .busy        (busy),
    .done        (done),
    .legal       (legal),
    .flip_count  (flip_count),
    .ram_addr    (ram_addr),
    .ram_wdata   (ram_wdata),
    .ram_wren    (ram_wren),
    .ram_rdata   (ram_rdata)
  );

  typedef struct {
    logic       legal;
    logic [4:0] flips;
    int         nwr;
  } res_t;

  typedef struct {
    logic [6:0] addr;
    logic [1:0] data;
  } wr_t;

  res_t       exp_q[$];
  wr_t        wr_q[$];
  logic [1:0] mem [0:127];
  int         nvec;
  int         nerr;
  int         wr_cnt;
  bit         addr_seen;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (ram_wren) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  always @(negedge clock) begin
    if (busy && ram_addr != 7'd0) addr_seen = 1'b1;
    if (ram_wren) begin
      wr_t w;
      wr_cnt++;
      if (wr_q.size() == 0) begin
        chk("unexpected_write", {25'd0, ram_addr}, 32'hFFFF);
      end else begin
        w = wr_q.pop_front();
        chk("wr_addr", {25'd0, ram_addr}, {25'd0, w.addr});
        chk("wr_data", {30'd0, ram_wdata}, {30'd0, w.data});
      end
    end
  end

  task automatic fresh_board();
    for (int i = 0; i < 128; i++) mem[i] = 2'b00;
    for (int i = 0; i < 10; i++) begin
      mem[i]      = 2'b11;
      mem[90 + i] = 2'b11;
      mem[i * 10] = 2'b11;
      mem[i * 10 + 9] = 2'b11;
    end
    mem[44] = 2'b01;
    mem[45] = 2'b10;
    mem[54] = 2'b10;
    mem[55] = 2'b01;
  endtask

  task automatic push_res(input logic l,
                          input logic [4:0] f,
                          input int n);
    res_t r;
    r.legal = l;
    r.flips = f;
    r.nwr   = n;
    exp_q.push_back(r);
  endtask

  task automatic push_wr(input logic [6:0] a,
                         input logic [1:0] d);
    wr_t w;
    w.addr = a;
    w.data = d;
    wr_q.push_back(w);
  endtask

  task automatic wait_done(input string tag);
    bit got;
    res_t e;
    got = 1'b0;
    for (int n = 0; n < 400; n++) begin
      if (done) begin
        got = 1'b1;
        break;
      end
      @(negedge clock);
    end
    chk({tag, ".done_seen"}, {31'd0, got}, 32'd1);
    if (exp_q.size() == 0) begin
      chk({tag, ".no_expectation"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      chk({tag, ".legal"}, {31'd0, legal}, {31'd0, e.legal});
      chk({tag, ".flips"}, {27'd0, flip_count},
          {27'd0, e.flips});
      chk({tag, ".busy_at_done"}, {31'd0, busy}, 32'd0);
      chk({tag, ".nwrites"}, wr_cnt, e.nwr);
    end
    @(negedge clock);
    chk({tag, ".done_pulse"}, {31'd0, done}, 32'd0);
  endtask

  task automatic do_req(input string tag,
                        input logic [6:0] p,
                        input logic [1:0] pl,
                        input bit noread);
    wr_cnt    = 0;
    addr_seen = 1'b0;
    @(negedge clock);
    start  = 1'b1;
    pos    = p;
    player = pl;
    @(negedge clock);
    start = 1'b0;
    chk({tag, ".busy"}, {31'd0, busy}, 32'd1);
    wait_done(tag);
    if (noread)
      chk({tag, ".no_read"}, {31'd0, addr_seen}, 32'd0);
  endtask

  initial begin
    bit saw;
    nvec        = 0;
    nerr        = 0;
    wr_cnt      = 0;
    addr_seen   = 1'b0;
    reset       = 1'b0;
    board_ready = 1'b0;
    start       = 1'b0;
    pos         = '0;
    player      = '0;
    fresh_board();
    #12;
    chk("rst.busy", {31'd0, busy}, 32'd0);
    chk("rst.done", {31'd0, done}, 32'd0);
    chk("rst.legal", {31'd0, legal}, 32'd0);
    chk("rst.flips", {27'd0, flip_count}, 32'd0);
    chk("rst.addr", {25'd0, ram_addr}, 32'd0);
    chk("rst.wdata", {30'd0, ram_wdata}, 32'd0);
    chk("rst.wren", {31'd0, ram_wren}, 32'd0);
    @(negedge clock);
    reset = 1'b1;

    // start while board not ready is ignored
    @(negedge clock);
    start = 1'b1;
    pos   = 7'd35;
    player = 2'b01;
    @(negedge clock);
    start = 1'b0;
    chk("notready.busy", {31'd0, busy}, 32'd0);
    board_ready = 1'b1;

    fresh_board();
    push_wr(7'd45, 2'b01);
    push_wr(7'd35, 2'b01);
    push_res(1'b1, 5'd1, 2);
    do_req("t1", 7'd35, 2'b01, 1'b0);
    chk("t1.mem45", {30'd0, mem[45]}, 32'd1);
    chk("t1.mem35", {30'd0, mem[35]}, 32'd1);

    fresh_board();
    push_wr(7'd54, 2'b01);
    push_wr(7'd53, 2'b01);
    push_res(1'b1, 5'd1, 2);
    do_req("t2", 7'd53, 2'b01, 1'b0);

    fresh_board();
    push_res(1'b0, 5'd0, 0);
    do_req("t3", 7'd44, 2'b10, 1'b0);

    push_res(1'b0, 5'd0, 0);
    do_req("t4.pos0", 7'd0, 2'b01, 1'b1);
    push_res(1'b0, 5'd0, 0);
    do_req("t4.pos100", 7'd100, 2'b01, 1'b1);
    push_res(1'b0, 5'd0, 0);
    do_req("t4.p00", 7'd35, 2'b00, 1'b1);

    fresh_board();
    mem[40] = 2'b11;
    for (int i = 41; i <= 46; i++) mem[i] = 2'b10;
    mem[47] = 2'b00;
    mem[48] = 2'b00;
    push_res(1'b0, 5'd0, 0);
    do_req("t5", 7'd47, 2'b01, 1'b0);

    // five-disc bracket on the left ray
    mem[41] = 2'b01;
    for (int a = 46; a >= 42; a--) push_wr(7'(a), 2'b01);
    push_wr(7'd47, 2'b01);
    push_res(1'b1, 5'd5, 6);
    do_req("t5b", 7'd47, 2'b01, 1'b0);
    chk("t5b.mem42", {30'd0, mem[42]}, 32'd1);

    // a second start while busy is ignored
    fresh_board();
    push_wr(7'd45, 2'b01);
    push_wr(7'd35, 2'b01);
    push_res(1'b1, 5'd1, 2);
    wr_cnt = 0;
    @(negedge clock);
    start  = 1'b1;
    pos    = 7'd35;
    player = 2'b01;
    @(negedge clock);
    pos    = 7'd53;
    player = 2'b10;
    @(negedge clock);
    start = 1'b0;
    wait_done("t6a");
    saw = 1'b0;
    for (int n = 0; n < 8; n++) begin
      if (done || busy) saw = 1'b1;
      @(negedge clock);
    end
    chk("t6a.no_second", {31'd0, saw}, 32'd0);

    // reset in the middle of a flip
    fresh_board();
    push_wr(7'd45, 2'b01);
    @(negedge clock);
    start  = 1'b1;
    pos    = 7'd35;
    player = 2'b01;
    @(negedge clock);
    start = 1'b0;
    saw = 1'b0;
    for (int n = 0; n < 400; n++) begin
      if (ram_wren) begin
        saw = 1'b1;
        break;
      end
      @(negedge clock);
    end
    chk("t6b.flip_seen", {31'd0, saw}, 32'd1);
    #1 reset = 1'b0;
    #1;
    chk("t6b.busy", {31'd0, busy}, 32'd0);
    chk("t6b.wren", {31'd0, ram_wren}, 32'd0);
    chk("t6b.addr", {25'd0, ram_addr}, 32'd0);
    chk("t6b.wdata", {30'd0, ram_wdata}, 32'd0);
    chk("t6b.done", {31'd0, done}, 32'd0);
    chk("t6b.legal", {31'd0, legal}, 32'd0);
    wr_q.delete();
    exp_q.delete();
    @(negedge clock);
    reset = 1'b1;

    fresh_board();
    push_wr(7'd54, 2'b01);
    push_wr(7'd53, 2'b01);
    push_res(1'b1, 5'd1, 2);
    do_req("t6c", 7'd53, 2'b01, 1'b0);
    chk("end.wr_q_empty", wr_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule
